// File: rtl/key_event.sv
// key_event: turns debounced key levels into single-cycle press, release, long-press and repeat pulses
module key_event #(
   parameter int SW_WIDTH   = 1,
   parameter int CNT_WIDTH  = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic [SW_WIDTH-1:0]  sw_in,
   input  logic [CNT_WIDTH-1:0] long_ticks,
   input  logic [CNT_WIDTH-1:0] repeat_ticks,
   output logic [SW_WIDTH-1:0]  press,
   output logic [SW_WIDTH-1:0]  release_,
   output logic [SW_WIDTH-1:0]  long_press,
   output logic [SW_WIDTH-1:0]  repeat_,
   output logic [SW_WIDTH-1:0]  held
);
   typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   for (genvar k = 0; k < SW_WIDTH; k++) begin : g_key
      state_t               st;
      logic [CNT_WIDTH-1:0] cnt;
      logic                 p, sat, long_hit, rep_hit;
      logic                 pr, rl, lp, rp, hd;
      assign p        = sw_in[k] ^ ACTIVE_LOW;
      assign sat      = &cnt;
      assign long_hit = tick && long_ticks != '0 && cnt == long_ticks - ONE;
      assign rep_hit  = tick && repeat_ticks != '0 && cnt == repeat_ticks - ONE;
      // per-key FSM; release outranks tick, pulses and held are registered with the state
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st  <= IDLE;
            cnt <= '0;
            pr  <= 1'b0;
            rl  <= 1'b0;
            lp  <= 1'b0;
            rp  <= 1'b0;
            hd  <= 1'b0;
         end else begin
            pr <= 1'b0;
            rl <= 1'b0;
            lp <= 1'b0;
            rp <= 1'b0;
            case (st)
               IDLE:
                  if (p) begin
                     pr  <= 1'b1;
                     cnt <= '0;
                     st  <= PRESSED;
                     hd  <= 1'b1;
                  end
               PRESSED:
                  if (!p) begin
                     rl <= 1'b1;
                     st <= IDLE;
                     hd <= 1'b0;
                  end else if (long_hit) begin
                     lp  <= 1'b1;
                     cnt <= '0;
                     st  <= REPEAT;
                  end else if (tick && !sat) cnt <= cnt + ONE;
               REPEAT:
                  if (!p) begin
                     rl <= 1'b1;
                     st <= IDLE;
                     hd <= 1'b0;
                  end else if (rep_hit) begin
                     rp  <= 1'b1;
                     cnt <= '0;
                  end else if (tick && !sat) cnt <= cnt + ONE;
               default: begin
                  st <= IDLE;
                  hd <= 1'b0;
               end
            endcase
         end
      end
      assign press[k]      = pr;
      assign release_[k]   = rl;
      assign long_press[k] = lp;
      assign repeat_[k]    = rp;
      assign held[k]       = hd;
   end
endmodule
